stopwatch_ctrl: RTL and testbench



---
 rtl/stopwatch_pkg.sv | 21 ++
 rtl/stopwatch_ctrl_if.sv | 28 ++
 rtl/stopwatch_ctrl_tick_gen.sv | 39 +++
 rtl/stopwatch_ctrl.sv | 122 ++++++++++++
 tb/tb_stopwatch_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch sequencing controller.
// Contents: FSM state encoding, seconds bus width, default saturation value,
// and a helper that tells whether a state advances the count.
package stopwatch_pkg;

   localparam int SECONDS_W       = 13;
   localparam int MAX_SECONDS_DEF = 5999;

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      PAUSE,
      LAP,
      FULL
   } sw_state_t;

   function automatic logic is_counting(sw_state_t st);
      return (st == RUN) || (st == LAP);
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button-pulse and display-status bundle for the stopwatch controller.
// Signals:
//   start_stop_i, clear_i, lap_i    single-cycle debounced button pulses
//   seconds_o                       seconds value for the MM:SS digit parser
//   running_o, lap_hold_o, full_o   status flags
// Modports: master = button/display side, slave = stopwatch_ctrl.
interface stopwatch_ctrl_if;
   import stopwatch_pkg::*;

   logic                 start_stop_i;
   logic                 clear_i;
   logic                 lap_i;
   logic [SECONDS_W-1:0] seconds_o;
   logic                 running_o;
   logic                 lap_hold_o;
   logic                 full_o;

   modport master (
      output start_stop_i, clear_i, lap_i,
      input  seconds_o, running_o, lap_hold_o, full_o
   );

   modport slave (
      input  start_stop_i, clear_i, lap_i,
      output seconds_o, running_o, lap_hold_o, full_o
   );

endinterface

// File: rtl/stopwatch_ctrl_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV enabled cycles.
// The phase is held while disabled so pause/resume keeps second length exact.
// Ports:
//   clk, reset_n   system clock, async active-low reset
//   enable_i       prescaler advances while high
//   clear_i        zeroes the prescaler (overrides enable_i)
//   tick_o         high for the enabled cycle in which the prescaler wraps
module tick_gen #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic enable_i,
   input  logic clear_i,
   output logic tick_o
);

   localparam int              PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] LAST = PRE_W'(TICK_DIV - 1);

   logic [PRE_W-1:0] prescaler;

   assign tick_o = enable_i && (prescaler == LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prescaler <= '0;
      end else if (clear_i) begin
         prescaler <= '0;
      end else if (enable_i) begin
         if (prescaler == LAST) begin
            prescaler <= '0;
         end else begin
            prescaler <= prescaler + PRE_W'(1);
         end
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: elapsed-seconds counter with run, pause,
// lap freeze and saturation, feeding the MM:SS digit parser.
// Ports:
//   clk, reset_n   system clock, async active-low reset
//   sw             button pulses in, seconds value and status flags out
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | count at zero, waiting for start
// RUN   | counting, live value displayed
// PAUSE | count and prescaler phase held
// LAP   | counting, display frozen at lap_value
// FULL  | count saturated at MAX_SECONDS, only clear leaves
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV    = 50_000_000,
   parameter int MAX_SECONDS = MAX_SECONDS_DEF
) (
   input  logic       clk,
   input  logic       reset_n,
   stopwatch_ctrl_if.slave sw
);

   localparam logic [SECONDS_W-1:0] MAX_C  = SECONDS_W'(MAX_SECONDS);
   localparam logic [SECONDS_W-1:0] LAST_C = SECONDS_W'(MAX_SECONDS - 1);

   sw_state_t            state;
   sw_state_t            state_nxt;
   logic [SECONDS_W-1:0] count;
   logic [SECONDS_W-1:0] lap_value;
   logic                 tick;
   logic                 counting;
   logic                 reach_full;
   logic                 lap_capture;

   assign counting = is_counting(state);

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
      .clk      (clk),
      .reset_n  (reset_n),
      .enable_i (counting),
      .clear_i  (sw.clear_i),
      .tick_o   (tick)
   );

   // Saturation takes precedence over start/stop and lap in the same cycle.
   assign reach_full = tick && (count == LAST_C);

   always_comb begin
      state_nxt   = state;
      lap_capture = 1'b0;
      if (sw.clear_i) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (sw.start_stop_i) state_nxt = RUN;
            end
            RUN: begin
               if (reach_full) begin
                  state_nxt = FULL;
               end else if (sw.start_stop_i) begin
                  state_nxt = PAUSE;
               end else if (sw.lap_i) begin
                  state_nxt   = LAP;
                  lap_capture = 1'b1;
               end
            end
            LAP: begin
               if (reach_full) begin
                  state_nxt = FULL;
               end else if (sw.start_stop_i) begin
                  state_nxt = PAUSE;
               end else if (sw.lap_i) begin
                  state_nxt = RUN;
               end
            end
            PAUSE: begin
               if (sw.start_stop_i) state_nxt = RUN;
            end
            FULL:    state_nxt = FULL;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (sw.clear_i) begin
         count <= '0;
      end else if (tick && (count < MAX_C)) begin
         count <= count + SECONDS_W'(1);
      end
   end

   // Captures the pre-increment count when a tick lands in the lap cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lap_value <= '0;
      end else if (sw.clear_i) begin
         lap_value <= '0;
      end else if (lap_capture) begin
         lap_value <= count;
      end
   end

   assign sw.running_o  = counting;
   assign sw.lap_hold_o = (state == LAP);
   assign sw.full_o     = (state == FULL);
   assign sw.seconds_o  = (state == LAP) ? lap_value : count;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: two instances (TICK_DIV=4 with the
// default saturation, and TICK_DIV=4 with MAX_SECONDS=10). Expected output
// snapshots are queued with the cycle they are due and compared at the
// falling edge after that cycle's rising edge.
module tb_stopwatch_ctrl;
   import stopwatch_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   int unsigned cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   stopwatch_ctrl_if swa ();
   stopwatch_ctrl_if swb ();

   stopwatch_ctrl #(.TICK_DIV(4), .MAX_SECONDS(5999)) dut_a (
      .clk     (clk),
      .reset_n (reset_n),
      .sw      (swa.slave)
   );

   stopwatch_ctrl #(.TICK_DIV(4), .MAX_SECONDS(10)) dut_b (
      .clk     (clk),
      .reset_n (reset_n),
      .sw      (swb.slave)
   );

   typedef struct {
      int unsigned due;
      int          unit;
      string       tag;
      logic [15:0] val;   // {seconds, running, lap_hold, full}
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   function automatic logic [15:0] observe(int unit);
      if (unit == 0)
         return {swa.seconds_o, swa.running_o, swa.lap_hold_o, swa.full_o};
      else
         return {swb.seconds_o, swb.running_o, swb.lap_hold_o, swb.full_o};
   endfunction

   task automatic expect_at(int unsigned due, int unit, string tag,
                            int sec, bit run, bit hold, bit full);
      exp_t e;
      e.due  = due;
      e.unit = unit;
      e.tag  = tag;
      e.val  = {13'(sec), run, hold, full};
      sb.push_back(e);
   endtask

   task automatic compare(exp_t e);
      logic [15:0] o;
      o = observe(e.unit);
      checks++;
      assert (o === e.val) else begin
         errors++;
         $error("FAIL %s unit=%0d cyc=%0d: got sec=%0d run=%b hold=%b full=%b, expected sec=%0d run=%b hold=%b full=%b",
                e.tag, e.unit, cyc, o[15:3], o[2], o[1], o[0],
                e.val[15:3], e.val[2], e.val[1], e.val[0]);
      end
   endtask

   task automatic drain();
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due <= cyc) begin
            compare(sb[i]);
            sb.delete(i);
         end
      end
   endtask

   task automatic tick(int n);
      repeat (n) begin
         @(negedge clk);
         drain();
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse(int unit, bit ss, bit clr, bit lp);
      if (unit == 0) begin
         swa.start_stop_i = ss;
         swa.clear_i      = clr;
         swa.lap_i        = lp;
      end else begin
         swb.start_stop_i = ss;
         swb.clear_i      = clr;
         swb.lap_i        = lp;
      end
      tick(1);
      swa.start_stop_i = 1'b0;
      swa.clear_i      = 1'b0;
      swa.lap_i        = 1'b0;
      swb.start_stop_i = 1'b0;
      swb.clear_i      = 1'b0;
      swb.lap_i        = 1'b0;
   endtask

   initial begin
      int unsigned n, p, r, l, s, t, u, b;
      exp_t        e;

      reset_n          = 1'b0;
      swa.start_stop_i = 1'b0;
      swa.clear_i      = 1'b0;
      swa.lap_i        = 1'b0;
      swb.start_stop_i = 1'b0;
      swb.clear_i      = 1'b0;
      swb.lap_i        = 1'b0;

      tick(2);
      expect_at(cyc, 0, "reset_a", 0, 0, 0, 0);
      expect_at(cyc, 1, "reset_b", 0, 0, 0, 0);
      tick(1);
      reset_n = 1'b1;
      tick(1);

      // start and count three seconds
      pulse(0, 1, 0, 0);
      n = cyc;
      expect_at(n,      0, "start",        0, 1, 0, 0);
      expect_at(n + 3,  0, "before_tick1", 0, 1, 0, 0);
      expect_at(n + 4,  0, "sec1",         1, 1, 0, 0);
      expect_at(n + 8,  0, "sec2",         2, 1, 0, 0);
      expect_at(n + 12, 0, "sec3",         3, 1, 0, 0);
      tick(12);

      // pause with three prescaler steps taken, lap ignored while paused
      tick(2);
      pulse(0, 1, 0, 0);
      p = cyc;
      expect_at(p, 0, "pause", 3, 0, 0, 0);
      tick(4);
      pulse(0, 0, 0, 1);
      expect_at(p + 5,  0, "pause_lap_ignored", 3, 0, 0, 0);
      expect_at(p + 10, 0, "pause_hold",        3, 0, 0, 0);
      tick(5);

      // resume: one cycle left in the preserved phase
      pulse(0, 1, 0, 0);
      r = cyc;
      expect_at(r,     0, "resume",      3, 1, 0, 0);
      expect_at(r + 1, 0, "resume_tick", 4, 1, 0, 0);
      expect_at(r + 4, 0, "sec4_hold",   4, 1, 0, 0);
      expect_at(r + 5, 0, "sec5",        5, 1, 0, 0);
      tick(5);

      // lap at 5, counting continues underneath
      pulse(0, 0, 0, 1);
      l = cyc;
      expect_at(l,     0, "lap_freeze",   5, 1, 1, 0);
      expect_at(l + 3, 0, "lap_counting", 5, 1, 1, 0);
      expect_at(l + 8, 0, "lap_still",    5, 1, 1, 0);
      tick(8);
      pulse(0, 0, 0, 1);
      expect_at(l + 9, 0, "lap_release", 7, 1, 0, 0);
      tick(1);

      // tick and start_stop together: increment lands, then pause
      pulse(0, 1, 0, 0);
      expect_at(l + 11, 0, "tick_and_pause", 8, 0, 0, 0);

      // resume, then clear+start_stop on a tick cycle
      pulse(0, 1, 0, 0);
      s = cyc;
      expect_at(s, 0, "resume2", 8, 1, 0, 0);
      tick(3);
      pulse(0, 1, 1, 0);
      expect_at(s + 4,  0, "clear_tick_ss",    0, 0, 0, 0);
      expect_at(s + 10, 0, "idle_after_clear", 0, 0, 0, 0);
      tick(6);

      // restart from a cleared prescaler, then async reset between edges
      pulse(0, 1, 0, 0);
      t = cyc;
      expect_at(t + 4, 0, "restart_sec1", 1, 1, 0, 0);
      tick(5);
      #2;
      reset_n = 1'b0;
      #1;
      e.due = cyc; e.unit = 0; e.tag = "async_reset_a"; e.val = '0;
      compare(e);
      e.unit = 1; e.tag = "async_reset_b";
      compare(e);
      tick(1);
      reset_n = 1'b1;
      expect_at(cyc + 8, 0, "idle_after_reset", 0, 0, 0, 0);
      tick(8);
      pulse(0, 1, 0, 0);
      u = cyc;
      expect_at(u,     0, "start_after_reset", 0, 1, 0, 0);
      expect_at(u + 4, 0, "sec1_after_reset",  1, 1, 0, 0);
      tick(4);

      // saturation at MAX_SECONDS=10, lap freeze dropped on entry
      pulse(1, 1, 0, 0);
      b = cyc;
      expect_at(b + 4,  1, "b_sec1", 1, 1, 0, 0);
      expect_at(b + 36, 1, "b_sec9", 9, 1, 0, 0);
      tick(36);
      pulse(1, 0, 0, 1);
      expect_at(b + 37, 1, "b_lap",      9,  1, 1, 0);
      expect_at(b + 39, 1, "b_lap_held", 9,  1, 1, 0);
      expect_at(b + 40, 1, "b_full",     10, 0, 0, 1);
      tick(3);
      pulse(1, 1, 0, 0);
      expect_at(b + 41, 1, "full_ss_ignored", 10, 0, 0, 1);
      pulse(1, 0, 0, 1);
      expect_at(b + 42, 1, "full_lap_ignored", 10, 0, 0, 1);
      expect_at(b + 46, 1, "full_hold",        10, 0, 0, 1);
      tick(4);
      pulse(1, 0, 1, 0);
      expect_at(b + 47, 1, "full_clear", 0, 0, 0, 0);
      tick(2);

      checks++;
      assert (sb.size() === 0) else begin
         errors++;
         $error("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
